uart_rx_oversampler: RTL and testbench

- Serial receive front end, directly downstream of the baud generator.
- Consumes the 16x baud strobe and the asynchronous rx pin.
- Recovers 8-bit frames (start, 8 data LSB-first, optional parity, 1 stop) using mid-bit majority-vote sampling.
- Delivers each byte with a one-cycle valid pulse and error flags to the UART controller.

---
 rtl/uart_rx_oversampler_if.sv | 32 +++
 rtl/uart_rx_oversampler.sv | 163 ++++++++++++++++
 tb/tb_uart_rx_oversampler.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_oversampler_if.sv
// rtl/uart_rx_oversampler_if.sv - tick/rx inputs and received byte/flag outputs of the UART receiver
interface uart_rx_oversampler_if;
  logic       baud16x_tick;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       parity_err;
  logic       rx_busy;

  // Receiver side: consumes tick and line, drives byte and status
  modport slave (
    input  baud16x_tick,
    input  rx,
    output rx_data,
    output rx_valid,
    output frame_err,
    output parity_err,
    output rx_busy
  );

  // Controller side: supplies tick and line, observes byte and status
  modport master (
    output baud16x_tick,
    output rx,
    input  rx_data,
    input  rx_valid,
    input  frame_err,
    input  parity_err,
    input  rx_busy
  );
endinterface

// File: rtl/uart_rx_oversampler.sv
// rtl/uart_rx_oversampler.sv - 16x oversampling UART receiver with mid-bit majority vote
module uart_rx_oversampler #(
  parameter bit PARITY_EN  = 1'b0,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  uart_rx_oversampler_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] tick_cnt_q, tick_cnt_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic       samp7_q, samp7_d;
  logic       samp8_q, samp8_d;
  logic       par_bad_q, par_bad_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       frame_err_q, frame_err_d;
  logic       parity_err_q, parity_err_d;
  logic       rx_meta_q, rx_sync_q;
  logic       tick;
  logic       vote;

  assign tick = bus.baud16x_tick;

  // Third sample is taken live at tick 9 and voted with the two stored ones
  assign vote = (samp7_q & samp8_q) | (samp7_q & rx_sync_q) | (samp8_q & rx_sync_q);

  // Two-flop synchronizer for the asynchronous line; resets to idle-high
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= bus.rx;
      rx_sync_q <= rx_meta_q;
    end
  end

  // Frame state, counters, samples and registered outputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= S_IDLE;
      tick_cnt_q   <= 4'd0;
      bit_cnt_q    <= 3'd0;
      shift_q      <= 8'd0;
      samp7_q      <= 1'b0;
      samp8_q      <= 1'b0;
      par_bad_q    <= 1'b0;
      rx_data_q    <= 8'd0;
      rx_valid_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      tick_cnt_q   <= tick_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      samp7_q      <= samp7_d;
      samp8_q      <= samp8_d;
      par_bad_q    <= par_bad_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
    end
  end

  // Next-state logic; everything advances only on tick edges, pulses self-clear every clk
  always_comb begin
    state_d      = state_q;
    tick_cnt_d   = tick_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    samp7_d      = samp7_q;
    samp8_d      = samp8_q;
    par_bad_d    = par_bad_q;
    rx_data_d    = rx_data_q;
    rx_valid_d   = 1'b0;
    frame_err_d  = 1'b0;
    parity_err_d = 1'b0;

    if (tick) begin
      if (state_q != S_IDLE) begin
        tick_cnt_d = tick_cnt_q + 4'd1;
        if (tick_cnt_q == 4'd7) samp7_d = rx_sync_q;
        if (tick_cnt_q == 4'd8) samp8_d = rx_sync_q;
      end

      case (state_q)
        S_IDLE: begin
          if (!rx_sync_q) begin
            state_d    = S_START;
            tick_cnt_d = 4'd0;
            par_bad_d  = 1'b0;
          end
        end

        S_START: begin
          if (tick_cnt_q == 4'd9 && vote) begin
            // Line back high at mid start bit: treat as noise, no flags
            state_d    = S_IDLE;
            tick_cnt_d = 4'd0;
          end else if (tick_cnt_q == 4'd15) begin
            state_d   = S_DATA;
            bit_cnt_d = 3'd0;
          end
        end

        S_DATA: begin
          if (tick_cnt_q == 4'd9) shift_d = {vote, shift_q[7:1]};
          if (tick_cnt_q == 4'd15) begin
            if (bit_cnt_q == 3'd7) state_d = PARITY_EN ? S_PARITY : S_STOP;
            else                   bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end

        S_PARITY: begin
          if (tick_cnt_q == 4'd9) par_bad_d = ((^shift_q) ^ vote) != PARITY_ODD;
          if (tick_cnt_q == 4'd15) state_d = S_STOP;
        end

        S_STOP: begin
          // Resolve at mid stop bit and leave at once so the next start edge is caught early
          if (tick_cnt_q == 4'd9) begin
            state_d    = S_IDLE;
            tick_cnt_d = 4'd0;
            if (!vote) begin
              frame_err_d = 1'b1;
            end else if (par_bad_q) begin
              parity_err_d = 1'b1;
            end else begin
              rx_data_d  = shift_q;
              rx_valid_d = 1'b1;
            end
          end
        end

        default: begin
          state_d    = S_IDLE;
          tick_cnt_d = 4'd0;
        end
      endcase
    end
  end

  assign bus.rx_data    = rx_data_q;
  assign bus.rx_valid   = rx_valid_q;
  assign bus.frame_err  = frame_err_q;
  assign bus.parity_err = parity_err_q;
  assign bus.rx_busy    = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_oversampler.sv
// tb/tb_uart_rx_oversampler.sv - scoreboard bench for 8N1 and 8E1 receiver instances
module tb_uart_rx_oversampler;

  localparam int BIT_CLK = 96;
  localparam logic [1:0] K_VALID = 2'd0;
  localparam logic [1:0] K_FERR  = 2'd1;
  localparam logic [1:0] K_PERR  = 2'd2;

  typedef struct packed {
    logic [1:0]  kind;
    logic [7:0]  data;
    logic        chk_lat;
    logic [31:0] base;
    logic [31:0] lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tick = 1'b0;
  int unsigned tick_div = 0;
  int unsigned tick_ctr = 0;
  logic        rx_n_drv = 1'b1;
  logic        rx_p_drv = 1'b1;

  int   checks = 0;
  int   errors = 0;
  exp_t q_n[$];
  exp_t q_p[$];
  logic [7:0] last_good [2];
  int   pulses_n = 0;
  int   pulses_p = 0;
  bit   b2b_active = 1'b0;
  int   low_run = 0;
  int   max_low = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    tick_div <= (tick_div == 5) ? 0 : tick_div + 1;
    tick     <= (tick_div == 5);
    if (tick) tick_ctr <= tick_ctr + 1;
  end

  uart_rx_oversampler_if if_n ();
  uart_rx_oversampler_if if_p ();

  assign if_n.baud16x_tick = tick;
  assign if_p.baud16x_tick = tick;
  assign if_n.rx = rx_n_drv;
  assign if_p.rx = rx_p_drv;

  uart_rx_oversampler #(.PARITY_EN(1'b0), .PARITY_ODD(1'b0)) dut_n (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (if_n)
  );

  uart_rx_oversampler #(.PARITY_EN(1'b1), .PARITY_ODD(1'b0)) dut_p (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (if_p)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  task automatic hold(input int nclk);
    for (int i = 0; i < nclk; i++) @(posedge clk);
    if (nclk > 0) #1;
  endtask

  task automatic set_rx(input int inst, input logic v);
    if (inst == 0) rx_n_drv = v;
    else           rx_p_drv = v;
  endtask

  task automatic judge(input int inst, input logic v, input logic fe, input logic pe,
                       input logic [7:0] d, input exp_t e);
    string       tag;
    logic [2:0]  req;
    int unsigned lat;
    tag = (inst == 0) ? "8n1" : "8e1";
    req = (e.kind == K_VALID) ? 3'b100 : (e.kind == K_FERR) ? 3'b010 : 3'b001;
    chk({"pulse_kind_", tag}, {29'd0, v, fe, pe}, {29'd0, req});
    if (e.kind == K_VALID) last_good[inst] = e.data;
    chk({"rx_data_", tag}, {24'd0, d}, {24'd0, last_good[inst]});
    if (e.chk_lat) begin
      lat = tick_ctr - e.base;
      checks++;
      if (lat < e.lat || lat > e.lat + 2) begin
        errors++;
        $display("FAIL latency_%s: got %0d ticks required %0d..%0d", tag, lat, e.lat, e.lat + 2);
      end
    end
  endtask

  task automatic monitor_loop();
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        last_good[0] = 8'd0;
        last_good[1] = 8'd0;
      end else begin
        if (if_n.rx_valid || if_n.frame_err || if_n.parity_err) begin
          pulses_n++;
          if (q_n.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_pulse_8n1: got v=%0b fe=%0b pe=%0b required no pulse",
                     if_n.rx_valid, if_n.frame_err, if_n.parity_err);
          end else begin
            e = q_n.pop_front();
            judge(0, if_n.rx_valid, if_n.frame_err, if_n.parity_err, if_n.rx_data, e);
          end
        end
        if (if_p.rx_valid || if_p.frame_err || if_p.parity_err) begin
          pulses_p++;
          if (q_p.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_pulse_8e1: got v=%0b fe=%0b pe=%0b required no pulse",
                     if_p.rx_valid, if_p.frame_err, if_p.parity_err);
          end else begin
            e = q_p.pop_front();
            judge(1, if_p.rx_valid, if_p.frame_err, if_p.parity_err, if_p.rx_data, e);
          end
        end
        if (b2b_active) begin
          low_run = if_n.rx_busy ? 0 : low_run + 1;
          if (low_run > max_low) max_low = low_run;
        end
      end
    end
  endtask

  // Reference model: outcome follows from stop bit first, then parity, else good byte
  task automatic send_frame(input int inst, input logic [7:0] data, input bit par_ok,
                            input bit stop_ok, input bit chk_lat, input int glitch_bit);
    exp_t e;
    logic pbit;
    pbit      = (^data) ^ !par_ok;
    e.kind    = !stop_ok ? K_FERR : ((inst == 1 && !par_ok) ? K_PERR : K_VALID);
    e.data    = data;
    e.chk_lat = chk_lat;
    e.lat     = (inst == 1) ? 32'd170 : 32'd154;
    e.base    = tick_ctr;
    if (inst == 0) q_n.push_back(e);
    else           q_p.push_back(e);
    set_rx(inst, 1'b0);
    hold(BIT_CLK);
    for (int i = 0; i < 8; i++) begin
      set_rx(inst, data[i]);
      if (i == glitch_bit) begin
        hold(60);
        set_rx(inst, !data[i]);
        hold(6);
        set_rx(inst, data[i]);
        hold(30);
      end else begin
        hold(BIT_CLK);
      end
    end
    if (inst == 1) begin
      set_rx(inst, pbit);
      hold(BIT_CLK);
    end
    set_rx(inst, stop_ok);
    hold(BIT_CLK);
    set_rx(inst, 1'b1);
  endtask

  task automatic chk_quiet(input int inst, input string name);
    if (inst == 0)
      chk(name, {20'd0, if_n.rx_data, if_n.rx_valid, if_n.frame_err, if_n.parity_err, if_n.rx_busy}, 32'd0);
    else
      chk(name, {20'd0, if_p.rx_data, if_p.rx_valid, if_p.frame_err, if_p.parity_err, if_p.rx_busy}, 32'd0);
  endtask

  initial begin
    int start_cnt;
    logic [7:0] dn, dp;
    bit okn, okp, pk;

    fork
      monitor_loop();
    join_none

    rst_n = 1'b0;
    hold(5);
    chk_quiet(0, "reset_outputs_8n1");
    chk_quiet(1, "reset_outputs_8e1");
    rst_n = 1'b1;
    hold(200);
    chk_quiet(0, "idle_outputs_8n1");

    send_frame(0, 8'hA5, 1'b1, 1'b1, 1'b1, -1);
    hold(200);

    fork
      begin
        send_frame(0, 8'h00, 1'b1, 1'b1, 1'b1, -1);
        send_frame(0, 8'hFF, 1'b1, 1'b1, 1'b1, -1);
        send_frame(0, 8'h3C, 1'b1, 1'b1, 1'b1, -1);
      end
      begin
        hold(30);
        b2b_active = 1'b1;
      end
    join
    b2b_active = 1'b0;
    checks++;
    if (max_low >= BIT_CLK) begin
      errors++;
      $display("FAIL b2b_busy_gap: got %0d clk low required < %0d", max_low, BIT_CLK);
    end
    hold(200);

    set_rx(0, 1'b0);
    hold(18);
    chk("false_start_busy_high", {31'd0, if_n.rx_busy}, 32'd1);
    hold(6);
    set_rx(0, 1'b1);
    hold(66);
    chk("false_start_busy_low", {31'd0, if_n.rx_busy}, 32'd0);
    chk("false_start_data", {24'd0, if_n.rx_data}, {24'd0, last_good[0]});
    hold(200);

    send_frame(0, 8'h55, 1'b1, 1'b0, 1'b1, -1);
    hold(200);
    send_frame(0, 8'h12, 1'b1, 1'b1, 1'b1, -1);
    hold(200);

    begin
      exp_t e;
      e.kind = K_FERR; e.data = 8'h00; e.chk_lat = 1'b0; e.base = 32'd0; e.lat = 32'd0;
      q_n.push_back(e);
      q_n.push_back(e);
    end
    start_cnt = pulses_n;
    set_rx(0, 1'b0);
    for (int i = 0; i < 2400 && pulses_n < start_cnt + 2; i++) @(posedge clk);
    #1;
    set_rx(0, 1'b1);
    checks++;
    if (pulses_n < start_cnt + 2) begin
      errors++;
      $display("FAIL break_timeout: got %0d frame pulses required 2", pulses_n - start_cnt);
    end
    hold(66);
    chk("break_busy_low", {31'd0, if_n.rx_busy}, 32'd0);
    hold(200);

    send_frame(1, 8'h07, 1'b1, 1'b1, 1'b1, -1);
    hold(200);
    send_frame(1, 8'h07, 1'b0, 1'b1, 1'b1, -1);
    hold(200);
    send_frame(1, 8'hA5, 1'b1, 1'b1, 1'b1, -1);
    hold(200);

    fork
      begin
        for (int k = 0; k < 18; k++) begin
          dn  = 8'($urandom);
          okn = ($urandom % 6) != 0;
          send_frame(0, dn, 1'b1, okn, 1'b1, -1);
          hold(okn ? int'($urandom_range(1, 150)) : int'($urandom_range(110, 200)));
        end
      end
      begin
        for (int k = 0; k < 18; k++) begin
          dp  = 8'($urandom);
          pk  = ($urandom % 4) != 0;
          okp = ($urandom % 6) != 0;
          send_frame(1, dp, pk, okp, 1'b1, -1);
          hold(okp ? int'($urandom_range(1, 150)) : int'($urandom_range(110, 200)));
        end
      end
    join
    hold(300);

    send_frame(0, 8'h00, 1'b1, 1'b1, 1'b1, 3);
    hold(200);

    set_rx(0, 1'b0);
    hold(BIT_CLK * 3);
    chk("midframe_busy", {31'd0, if_n.rx_busy}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_quiet(0, "async_reset_outputs_8n1");
    chk_quiet(1, "async_reset_outputs_8e1");
    set_rx(0, 1'b1);
    @(posedge clk);
    #1;
    hold(3);
    rst_n = 1'b1;
    hold(2000);
    chk_quiet(0, "post_reset_quiet_8n1");

    chk("queue_empty_8n1", q_n.size(), 32'd0);
    chk("queue_empty_8e1", q_p.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
